// File: rtl/irs_arb_pkg.sv
// Shared helpers for the IRS round-robin arbiter: source-index width and
// rotating-priority pick.
package irs_arb_pkg;

  localparam int RR_MAX_REQ = 64;
  localparam int RR_IDX_W   = 6;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of valid scanning ptr, ptr+1, ... wrapping at n; -1 if none.
  function automatic int rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                 input int ptr, input int n);
    int pick;
    int idx;
    pick = -1;
    for (int i = 0; i < n; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (pick < 0 && valid[idx[RR_IDX_W-1:0]]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/irs_arb_skid.sv
// Two-entry registered output slice: entry0 drives the outputs, entry1 only
// absorbs a beat accepted while entry0 is stalled.
module irs_arb_skid #(
  parameter int DATA_W = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_vld,
  input  logic [DATA_W-1:0] push_data,
  output logic              room,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] ent0_p1;
  logic [DATA_W-1:0] ent1_p1;
  logic              vld0_p1;
  logic              vld1_p1;
  logic              pop;

  assign pop = vld0_p1 & out_rdy;

  // ---- slice control (entry1 is never valid while entry0 is empty)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
    end else if (!vld0_p1) begin
      vld0_p1 <= push_vld;
    end else if (pop) begin
      if (vld1_p1) vld1_p1 <= 1'b0;
      else         vld0_p1 <= push_vld;
    end else if (push_vld) begin
      vld1_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!vld0_p1 || (pop && !vld1_p1)) begin
      if (push_vld) ent0_p1 <= push_data;
    end else if (pop) begin
      ent0_p1 <= ent1_p1;
    end
    if (vld0_p1 && !pop && push_vld) ent1_p1 <= push_data;
  end

  assign room     = ~vld1_p1;
  assign out_vld  = vld0_p1;
  assign out_data = vld0_p1 ? ent0_p1 : '0;

endmodule

// File: rtl/irs_rr_arb.sv
// N-to-1 round-robin arbiter feeding a registered 2-entry output slice.
// Define IRS_ARB_LOCK_EN to hold the grant on one requester until its last_i beat.
module irs_rr_arb
  import irs_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int PYLD_W  = 32,
  localparam int SRC_W   = clog2_min1(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        valid_i,
  output logic [NUM_REQ-1:0]        ready_o,
  input  logic [NUM_REQ*PYLD_W-1:0] payload_i,
  input  logic [NUM_REQ-1:0]        last_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [PYLD_W-1:0]         payload_o,
  output logic [SRC_W-1:0]          src_o
);

  logic [SRC_W-1:0]  ptr_p0;
  logic [SRC_W-1:0]  ptr_next;
  logic [SRC_W-1:0]  g_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [PYLD_W-1:0] pay_mux;
  logic              room;
  logic              acc;
  int                pick;

`ifdef IRS_ARB_LOCK_EN
  logic              locked_p0;
  logic [SRC_W-1:0]  lock_src_p0;
  logic              g_last;
`else
  logic              unused_last;
  assign unused_last = ^last_i;
`endif

  always_comb begin
    pick  = rr_pick(RR_MAX_REQ'(valid_i), int'(ptr_p0), NUM_REQ);
    gnt   = '0;
    g_idx = '0;
    if (pick >= 0) g_idx = SRC_W'(pick);
    for (int i = 0; i < NUM_REQ; i++) gnt[i] = (pick == i);
`ifdef IRS_ARB_LOCK_EN
    // A locked requester keeps the grant even while it has nothing to send.
    if (locked_p0) begin
      g_idx = lock_src_p0;
      for (int i = 0; i < NUM_REQ; i++) gnt[i] = (lock_src_p0 == SRC_W'(i));
    end
`endif
  end

  always_comb begin
    pay_mux = '0;
`ifdef IRS_ARB_LOCK_EN
    g_last  = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_idx == SRC_W'(i)) begin
        pay_mux = payload_i[i*PYLD_W +: PYLD_W];
`ifdef IRS_ARB_LOCK_EN
        g_last  = last_i[i];
`endif
      end
    end
  end

  assign ready_o  = gnt & {NUM_REQ{room & ~rst}};
  assign acc      = |(valid_i & ready_o);
  assign ptr_next = (g_idx == SRC_W'(NUM_REQ-1)) ? '0 : g_idx + 1'b1;

  // ---- p0: arbitration state, advances only on an accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p0      <= '0;
`ifdef IRS_ARB_LOCK_EN
      locked_p0   <= 1'b0;
      lock_src_p0 <= '0;
`endif
    end else if (acc) begin
      ptr_p0      <= ptr_next;
`ifdef IRS_ARB_LOCK_EN
      locked_p0   <= ~g_last;
      lock_src_p0 <= g_idx;
`endif
    end
  end

  // ---- p1: registered output slice
  irs_arb_skid #(
    .DATA_W (PYLD_W + SRC_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (acc),
    .push_data ({g_idx, pay_mux}),
    .room      (room),
    .out_vld   (valid_o),
    .out_rdy   (ready_i),
    .out_data  ({src_o, payload_o})
  );

endmodule

// File: tb/tb_irs_rr_arb.sv
// Directed self-checking bench for irs_rr_arb (4 requesters, 32-bit payload).
module tb_irs_rr_arb;

  localparam int NUM_REQ = 4;
  localparam int PYLD_W  = 32;
  localparam int SRC_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        valid_i;
  logic [NUM_REQ-1:0]        ready_o;
  logic [NUM_REQ*PYLD_W-1:0] payload_i;
  logic [NUM_REQ-1:0]        last_i;
  logic                      valid_o;
  logic                      ready_i;
  logic [PYLD_W-1:0]         payload_o;
  logic [SRC_W-1:0]          src_o;

  int n_chk  = 0;
  int n_fail = 0;
  int exp5[$];

  always #5 clk = ~clk;

  irs_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .PYLD_W  (PYLD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .payload_i (payload_i),
    .last_i    (last_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .payload_o (payload_o),
    .src_o     (src_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pay(input int r, input logic [PYLD_W-1:0] v);
    payload_i[r*PYLD_W +: PYLD_W] = v;
  endtask

  initial begin
    rst       = 1'b1;
    valid_i   = 4'hF;
    last_i    = 4'hF;
    ready_i   = 1'b1;
    payload_i = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    // 1: reset holds everything idle
    tick();
    chk("rst_ready", 64'(ready_o), 64'h0);
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_payload", 64'(payload_o), 64'h0);
    chk("rst_src", 64'(src_o), 64'h0);
    tick();
    chk("rst_ready2", 64'(ready_o), 64'h0);
    chk("rst_valid2", 64'(valid_o), 64'h0);
    rst = 1'b0;
    #1;
    chk("first_gnt", 64'(ready_o), 64'h1);

    // 2: all requesters valid, full throughput rotation
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rot_valid", 64'(valid_o), 64'h1);
      chk("rot_src", 64'(src_o), 64'(k % 4));
      chk("rot_payload", 64'(payload_o), 64'(32'hA0 + (k % 4)));
    end
    valid_i = 4'h0;
    tick();
    chk("rot_drain", 64'(valid_o), 64'h0);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // 3: single requester, downstream stalled, skid fill and in-order drain
    ready_i = 1'b0;
    valid_i = 4'b0001;
    set_pay(0, 32'hAAAA);
    #1;
    chk("skid_rdyA", 64'(ready_o), 64'h1);
    tick();
    set_pay(0, 32'hBBBB);
    #1;
    chk("skid_rdyB", 64'(ready_o), 64'h1);
    chk("skid_outA", 64'(payload_o), 64'hAAAA);
    tick();
    set_pay(0, 32'hCCCC);
    #1;
    chk("skid_full", 64'(ready_o), 64'h0);
    tick();
    chk("skid_holdv", 64'(valid_o), 64'h1);
    chk("skid_hold", 64'(payload_o), 64'hAAAA);
    ready_i = 1'b1;
    #1;
    chk("skid_nocomb", 64'(ready_o), 64'h0);
    tick();
    chk("skid_outB", 64'(payload_o), 64'hBBBB);
    chk("skid_rdyC", 64'(ready_o), 64'h1);
    tick();
    chk("skid_vC", 64'(valid_o), 64'h1);
    chk("skid_outC", 64'(payload_o), 64'hCCCC);
    valid_i = 4'h0;
    tick();
    chk("skid_drain", 64'(valid_o), 64'h0);

    // 4: ptr=1 with requesters 0 and 2 valid
    set_pay(0, 32'hA0);
    valid_i = 4'b0101;
    #1;
    chk("p1_gnt2", 64'(ready_o), 64'h4);
    tick();
    chk("p1_src2", 64'(src_o), 64'h2);
    chk("p1_gnt0", 64'(ready_o), 64'h1);
    tick();
    chk("p1_src0", 64'(src_o), 64'h0);
    valid_i = 4'hF;
    #1;
    chk("p1_ptr", 64'(ready_o), 64'h2);
    valid_i = 4'h0;
    tick();
    chk("p1_drain", 64'(valid_o), 64'h0);

    // 5: requester 1 sends a 3-beat packet while 0 and 2 compete
`ifdef IRS_ARB_LOCK_EN
    exp5 = '{1, 1, 1, 2, 0};
`else
    exp5 = '{1, 2, 0, 1};
`endif
    valid_i = 4'b0111;
    last_i  = 4'b1101;
    #1;
    chk("pkt_gnt1", 64'(ready_o), 64'h2);
    tick();
    chk("pkt_src0", 64'(src_o), 64'(exp5[0]));
    valid_i = 4'b0101;
    #1;
`ifdef IRS_ARB_LOCK_EN
    chk("pkt_lockhold", 64'(ready_o), 64'h2);
`else
    chk("pkt_lockhold", 64'(ready_o), 64'h4);
`endif
    valid_i = 4'b0111;
    for (int j = 1; j < exp5.size(); j++) begin
      last_i[1] = (j >= 2);
      tick();
      chk("pkt_src", 64'(src_o), 64'(exp5[j]));
      chk("pkt_payload", 64'(payload_o), 64'(32'hA0 + exp5[j]));
    end
    valid_i = 4'h0;
    last_i  = 4'hF;
    tick();
    chk("pkt_drain", 64'(valid_o), 64'h0);

    // 6: reset with a full slice discards both beats
    ready_i = 1'b0;
    valid_i = 4'b0001;
    tick();
    tick();
    chk("rfull_ready", 64'(ready_o), 64'h0);
    chk("rfull_valid", 64'(valid_o), 64'h1);
    rst = 1'b1;
    #1;
    chk("rfull_rstrdy", 64'(ready_o), 64'h0);
    tick();
    chk("rfull_v0", 64'(valid_o), 64'h0);
    chk("rfull_pay0", 64'(payload_o), 64'h0);
    chk("rfull_src0", 64'(src_o), 64'h0);
    rst     = 1'b0;
    valid_i = 4'h0;
    ready_i = 1'b1;
    tick();
    chk("rfull_v1", 64'(valid_o), 64'h0);
    tick();
    chk("rfull_v2", 64'(valid_o), 64'h0);
    valid_i = 4'b0001;
    #1;
    chk("rfull_gnt0", 64'(ready_o), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
